// File: rtl/sdp_ram_reader.sv
// Read-side controller for a simple dual-port RAM used as FIFO storage.
// Optional build macro SDP_RAM_READER_PARITY_EN adds an even-parity bit on rdata and drives parity_err.
module sdp_ram_reader #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_BASE2 = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DEPTH_BASE2:0]   wr_ptr,
  output logic [DEPTH_BASE2:0]   rd_ptr,
  output logic [DEPTH_BASE2-1:0] raddr,
`ifdef SDP_RAM_READER_PARITY_EN
  input  logic [DATA_WIDTH:0]    rdata,
`else
  input  logic [DATA_WIDTH-1:0]  rdata,
`endif
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  input  logic                   flush,
  output logic [DEPTH_BASE2:0]   count,
  output logic                   ovf_err,
  output logic                   parity_err
);

  localparam int unsigned PW = DEPTH_BASE2 + 1;
  // Largest legal occupancy: exactly one full RAM.
  localparam logic [PW-1:0] FULL_CNT = {1'b1, {DEPTH_BASE2{1'b0}}};

  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  ovf_q, ovf_d;
  logic                  empty;
  logic                  fetch;
  logic [PW-1:0]         count_c;

  assign empty   = (wr_ptr == rd_ptr_q);
  assign count_c = wr_ptr - rd_ptr_q;
  assign fetch   = !flush && !empty && (!dout_valid_q || dout_ready);

  assign rd_ptr     = rd_ptr_q;
  assign raddr      = rd_ptr_q[DEPTH_BASE2-1:0];
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign count      = count_c;
  assign ovf_err    = ovf_q;

  // Next-state: flush beats fetch, fetch beats a plain handshake.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    ovf_d        = ovf_q;
    if (flush) begin
      rd_ptr_d     = wr_ptr;
      dout_valid_d = 1'b0;
      ovf_d        = 1'b0;
    end else begin
      if (fetch) begin
        dout_d       = rdata[DATA_WIDTH-1:0];
        dout_valid_d = 1'b1;
        rd_ptr_d     = rd_ptr_q + PW'(1);
      end else if (dout_valid_q && dout_ready) begin
        dout_valid_d = 1'b0;
      end
      if (count_c > FULL_CNT) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ovf_q        <= ovf_d;
    end
  end

`ifdef SDP_RAM_READER_PARITY_EN
  logic par_q, par_d;

  // Parity flag travels with the word held in dout.
  always_comb begin
    par_d = par_q;
    if (flush) begin
      par_d = 1'b0;
    end else if (fetch) begin
      par_d = (^rdata[DATA_WIDTH-1:0]) != rdata[DATA_WIDTH];
    end else if (dout_valid_q && dout_ready) begin
      par_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign parity_err = par_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdp_ram_reader.sv
// Directed bench for sdp_ram_reader: table-driven stream vectors plus wrap, overrun and parity sequences.
module tb_sdp_ram_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned DB = 4;
`ifdef SDP_RAM_READER_PARITY_EN
  localparam int unsigned RW = DW + 1;
`else
  localparam int unsigned RW = DW;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DB:0]   wr_ptr;
  logic [DB:0]   rd_ptr;
  logic [DB-1:0] raddr;
  logic [RW-1:0] rdata;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          flush;
  logic [DB:0]   count;
  logic          ovf_err;
  logic          parity_err;

  logic [RW-1:0] mem [16];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign rdata = mem[raddr];

  sdp_ram_reader #(.DATA_WIDTH(DW), .DEPTH_BASE2(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .raddr      (raddr),
    .rdata      (rdata),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .flush      (flush),
    .count      (count),
    .ovf_err    (ovf_err),
    .parity_err (parity_err)
  );

  function automatic logic [RW-1:0] mk(input logic [DW-1:0] d);
`ifdef SDP_RAM_READER_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [DB:0]   wr;
    logic          rdy;
    logic          fl;
    logic          v;
    logic [DW-1:0] d;
    logic [DB:0]   rp;
    logic [DB:0]   cnt;
    logic          ovf;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int sent, got;
    logic [DB:0] last_rp;
    logic seen16, seen0, ovf_seen;

    // Basic 4-word stream, then backpressure with 3 words.
    tbl[0]  = '{5'd4, 1'b1, 1'b0, 1'b1, 32'h100, 5'd1, 5'd3, 1'b0};
    tbl[1]  = '{5'd4, 1'b1, 1'b0, 1'b1, 32'h101, 5'd2, 5'd2, 1'b0};
    tbl[2]  = '{5'd4, 1'b1, 1'b0, 1'b1, 32'h102, 5'd3, 5'd1, 1'b0};
    tbl[3]  = '{5'd4, 1'b1, 1'b0, 1'b1, 32'h103, 5'd4, 5'd0, 1'b0};
    tbl[4]  = '{5'd4, 1'b1, 1'b0, 1'b0, 32'h103, 5'd4, 5'd0, 1'b0};
    tbl[5]  = '{5'd7, 1'b0, 1'b0, 1'b1, 32'h200, 5'd5, 5'd2, 1'b0};
    tbl[6]  = '{5'd7, 1'b0, 1'b0, 1'b1, 32'h200, 5'd5, 5'd2, 1'b0};
    tbl[7]  = '{5'd7, 1'b0, 1'b0, 1'b1, 32'h200, 5'd5, 5'd2, 1'b0};
    tbl[8]  = '{5'd7, 1'b0, 1'b0, 1'b1, 32'h200, 5'd5, 5'd2, 1'b0};
    tbl[9]  = '{5'd7, 1'b0, 1'b0, 1'b1, 32'h200, 5'd5, 5'd2, 1'b0};
    tbl[10] = '{5'd7, 1'b1, 1'b0, 1'b1, 32'h201, 5'd6, 5'd1, 1'b0};
    tbl[11] = '{5'd7, 1'b1, 1'b0, 1'b1, 32'h202, 5'd7, 5'd0, 1'b0};
    tbl[12] = '{5'd7, 1'b1, 1'b0, 1'b0, 32'h202, 5'd7, 5'd0, 1'b0};

    for (int i = 0; i < 16; i++) mem[i] = mk(32'h0);
    for (int i = 0; i < 4; i++) mem[i] = mk(32'h100 + 32'(i));
    for (int i = 0; i < 3; i++) mem[4 + i] = mk(32'h200 + 32'(i));

    rst_n = 1'b0; wr_ptr = '0; dout_ready = 1'b0; flush = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // Idle after reset with an empty writer.
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("rst_valid", 64'(dout_valid), 64'(0));
      chk("rst_rd_ptr", 64'(rd_ptr), 64'(0));
      chk("rst_count", 64'(count), 64'(0));
      chk("rst_ovf", 64'(ovf_err), 64'(0));
    end
    chk("rst_dout", 64'(dout), 64'(0));
    chk("rst_parity", 64'(parity_err), 64'(0));

    for (int i = 0; i < 13; i++) begin
      wr_ptr = tbl[i].wr; dout_ready = tbl[i].rdy; flush = tbl[i].fl;
      tick();
      chk($sformatf("v%0d_valid", i), 64'(dout_valid), 64'(tbl[i].v));
      chk($sformatf("v%0d_dout", i), 64'(dout), 64'(tbl[i].d));
      chk($sformatf("v%0d_rd_ptr", i), 64'(rd_ptr), 64'(tbl[i].rp));
      chk($sformatf("v%0d_raddr", i), 64'(raddr), 64'(tbl[i].rp[DB-1:0]));
      chk($sformatf("v%0d_count", i), 64'(count), 64'(tbl[i].cnt));
      chk($sformatf("v%0d_ovf", i), 64'(ovf_err), 64'(tbl[i].ovf));
      chk($sformatf("v%0d_parity", i), 64'(parity_err), 64'(0));
    end

    // Wrap: 40 words with the writer one word per cycle, reader at full rate.
    sent = 0; got = 0; last_rp = rd_ptr;
    seen16 = 1'b0; seen0 = 1'b0; ovf_seen = 1'b0;
    dout_ready = 1'b1;
    for (int c = 0; c < 200 && got < 40; c++) begin
      if (sent < 40) begin
        mem[wr_ptr[DB-1:0]] = mk(32'h1000 + 32'(sent));
        wr_ptr = wr_ptr + 5'd1;
        sent++;
      end
      tick();
      if (last_rp == 5'd15 && rd_ptr == 5'd16) seen16 = 1'b1;
      if (last_rp == 5'd31 && rd_ptr == 5'd0) seen0 = 1'b1;
      last_rp = rd_ptr;
      if (ovf_err) ovf_seen = 1'b1;
      if (dout_valid) begin
        chk($sformatf("wrap_d%0d", got), 64'(dout), 64'(32'h1000 + 32'(got)));
        got++;
      end
    end
    chk("wrap_words", 64'(got), 64'(40));
    chk("wrap_15_16", 64'(seen16), 64'(1));
    chk("wrap_31_0", 64'(seen0), 64'(1));
    chk("wrap_ovf", 64'(ovf_seen), 64'(0));
    chk("wrap_rd_ptr", 64'(rd_ptr), 64'(15));
    tick();
    chk("wrap_drain_valid", 64'(dout_valid), 64'(0));

    // Overrun: writer 17 ahead, stalled consumer, then flush.
    rst_n = 1'b0; wr_ptr = '0; dout_ready = 1'b0; flush = 1'b0;
    tick();
    chk("rst2_rd_ptr", 64'(rd_ptr), 64'(0));
    rst_n = 1'b1;
    tick();
    wr_ptr = 5'd17;
    tick();
    chk("ovr_set", 64'(ovf_err), 64'(1));
    chk("ovr_rd_ptr", 64'(rd_ptr), 64'(1));
    tick();
    chk("ovr_hold", 64'(ovf_err), 64'(1));
    chk("ovr_stall_rd_ptr", 64'(rd_ptr), 64'(1));
    chk("ovr_count", 64'(count), 64'(16));
    chk("ovr_stall_valid", 64'(dout_valid), 64'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_rd_ptr", 64'(rd_ptr), 64'(17));
    chk("flush_valid", 64'(dout_valid), 64'(0));
    chk("flush_ovf", 64'(ovf_err), 64'(0));
    chk("flush_count", 64'(count), 64'(0));
    tick();
    chk("post_flush_valid", 64'(dout_valid), 64'(0));

`ifdef SDP_RAM_READER_PARITY_EN
    // Parity: bad parity on 0x1, good parity on 0x3.
    mem[1] = {1'b0, 32'h1};
    mem[2] = {1'b0, 32'h3};
    wr_ptr = 5'd19;
    tick();
    chk("par_bad_dout", 64'(dout), 64'(32'h1));
    chk("par_bad_flag", 64'(parity_err), 64'(1));
    dout_ready = 1'b1;
    tick();
    chk("par_good_dout", 64'(dout), 64'(32'h3));
    chk("par_good_flag", 64'(parity_err), 64'(0));
    tick();
    chk("par_drain_flag", 64'(parity_err), 64'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdp_ram_reader.md
Name: sdp_ram_reader

Overview:
Read-side controller for the simple dual-port RAM used as FIFO storage in the ASE hardware model. Tracks a read pointer against the writer's pointer and drives the RAM read address. The RAM has a combinational read port, so read data returns in the same cycle as the address. The block turns this into a registered valid/ready stream with full throughput. It also returns its pointer to the writer so the writer can detect full, and it reports occupancy and overrun.

Parameters:
DATA_WIDTH, 32, payload width of one RAM word
DEPTH_BASE2, 4, log2 of RAM depth; pointers are DEPTH_BASE2+1 bits, the extra MSB is the wrap bit

Ports:
clk  input  1  single clock; all state updates on posedge
rst_n  input  1  asynchronous, active-low reset
wr_ptr  input  DEPTH_BASE2+1  writer pointer including wrap bit, synchronous to clk
rd_ptr  output  DEPTH_BASE2+1  reader pointer including wrap bit, returned to writer for full detection
raddr  output  DEPTH_BASE2  RAM read address, equal to rd_ptr[DEPTH_BASE2-1:0]
rdata  input  DATA_WIDTH (+1 with parity option)  combinational RAM read data for raddr
dout  output  DATA_WIDTH  stream payload
dout_valid  output  1  stream valid
dout_ready  input  1  stream ready from consumer
flush  input  1  discard all unread entries and the output register
count  output  DEPTH_BASE2+1  unread entries in RAM, equal to wr_ptr - rd_ptr (mod 2^(DEPTH_BASE2+1)); excludes the word held in dout
ovf_err  output  1  sticky flag: writer overran the reader
parity_err  output  1  parity mismatch on the word currently in dout (optional feature)

Behaviour:
- Reset (rst_n=0, async): rd_ptr=0, dout=0, dout_valid=0, ovf_err=0, parity_err=0.
- Combinational signals:
  - empty = (wr_ptr == rd_ptr)
  - count = wr_ptr - rd_ptr, modulo arithmetic, DEPTH_BASE2+1 bits
  - raddr = rd_ptr low bits
- fetch = !flush && !empty && (!dout_valid || dout_ready).
- Register update priority per cycle:
  1. flush: rd_ptr<=wr_ptr, dout_valid<=0, ovf_err<=0. dout holds its value. Flush overrides an active fetch or handshake.
  2. fetch: dout<=rdata[DATA_WIDTH-1:0], dout_valid<=1, rd_ptr<=rd_ptr+1. Wrap-around is natural overflow of DEPTH_BASE2+1 bits, so the wrap bit toggles every 2^DEPTH_BASE2 reads.
  3. dout_valid && dout_ready && !fetch: dout_valid<=0.
  4. Otherwise hold.
- Latency: a word written at cycle N is visible via wr_ptr at N+1 and appears on dout_valid at N+2 (if the output register is free).
- Throughput: one word per cycle while not empty and dout_ready=1. Back-to-back handshake with simultaneous refill, no bubble.
- Stream rules:
  - dout and dout_valid stay stable while dout_valid && !dout_ready.
  - dout_valid does not depend combinationally on dout_ready.
- Empty boundary: when the last RAM entry is fetched, dout_valid stays 1 until handshaked, then drops unless the writer has advanced.
- Full boundary: count == 2^DEPTH_BASE2 is legal, fetch proceeds normally.
- Overrun: count > 2^DEPTH_BASE2 (unsigned) sets ovf_err<=1 next cycle. It holds until flush or reset. Data is undefined after overrun; the block keeps fetching.
- Reset mid-stream: all state clears immediately. The writer is expected to be reset together with the reader.

Optional Feature:
SDP_RAM_READER_PARITY_EN
- Defined:
  - rdata is DATA_WIDTH+1 bits; bit DATA_WIDTH is even parity written by the writer (^data).
  - On fetch, parity_err<=(^rdata[DATA_WIDTH-1:0]) != rdata[DATA_WIDTH].
  - parity_err is valid only while dout_valid=1 and stays aligned with the word in dout.
  - Cleared on flush and on handshake without refill.
- Not defined: rdata is DATA_WIDTH bits and parity_err is tied 0.

Test Plan:
All cases use DATA_WIDTH=32, DEPTH_BASE2=4.
- Reset, wr_ptr=0 -> dout_valid=0, rd_ptr=0, count=0, ovf_err=0 for 10 cycles.
- Writer stores 0x100..0x103 at addrs 0..3, wr_ptr=4, dout_ready=1 -> dout 0x100,0x101,0x102,0x103 on 4 consecutive cycles, then dout_valid=0, rd_ptr=4.
- Backpressure: 3 entries, dout_ready=0 for 5 cycles -> dout stable at first word, rd_ptr=1, count=2; release -> remaining 2 words in order with no gap.
- Wrap: stream 40 words through with the writer staying within 16 ahead -> rd_ptr sequence passes 15->16->31->0, data in order, ovf_err=0.
- Overrun then flush: wr_ptr=17 with rd_ptr=0 -> ovf_err=1 next cycle; flush=1 -> rd_ptr=17, dout_valid=0, ovf_err=0, count=0.
- Parity (macro defined): word 0x0000_0001 with parity bit 0 -> parity_err=1 with that word; next word 0x3 with parity bit 0 -> parity_err=0.
